// File: rtl/fighter_pkg.sv
// Shared fighter-game definitions: attack type codes, default position width
// and the hit resolver state encoding.
package fighter_pkg;

    // Default width of horizontal screen positions
    localparam int DEFAULT_X_W = 10;

    // Attack type codes carried on atk_type (3 is unused and means no attack)
    localparam logic [1:0] ATK_NONE = 2'd0;
    localparam logic [1:0] ATK1     = 2'd1;
    localparam logic [1:0] ATK2     = 2'd2;

    // Hit resolver states
    typedef enum logic [1:0] {
        RS_ARMED     = 2'd0,
        RS_CONNECTED = 2'd1,
        RS_KO        = 2'd2
    } resolver_state_t;

endpackage

// File: rtl/hitbox_overlap.sv
// Combinational 1-D overlap test between the attacker hitbox (extending
// `reach` pixels in front of the attacker) and the defender hurtbox
// (def_x +/- half_w). Math is done two bits wider and signed so that boxes
// running off either screen edge never wrap.
module hitbox_overlap #(
    parameter int X_W = 10
) (
    input  logic [X_W-1:0] atk_x,
    input  logic           atk_facing,
    input  logic [X_W-1:0] reach,
    input  logic [X_W-1:0] def_x,
    input  logic [X_W-1:0] half_w,
    output logic           overlap
);

    localparam int SW = X_W + 2;

    logic signed [SW-1:0] ax;
    logic signed [SW-1:0] rc;
    logic signed [SW-1:0] dx;
    logic signed [SW-1:0] hw;
    logic signed [SW-1:0] hit_lo;
    logic signed [SW-1:0] hit_hi;
    logic signed [SW-1:0] hurt_lo;
    logic signed [SW-1:0] hurt_hi;

    // Build both boxes and test for overlap; touching edges count as a hit
    always_comb begin
        ax      = $signed({2'b00, atk_x});
        rc      = $signed({2'b00, reach});
        dx      = $signed({2'b00, def_x});
        hw      = $signed({2'b00, half_w});
        hit_lo  = atk_facing ? ax : (ax - rc);
        hit_hi  = atk_facing ? (ax + rc) : ax;
        hurt_lo = dx - hw;
        hurt_hi = dx + hw;
        overlap = (hit_lo <= hurt_hi) && (hurt_lo <= hit_hi);
    end

endmodule

// File: rtl/hit_resolver.sv
// Resolves one attacker->defender direction: registers at most one hit per
// attack instance, applies damage or chip damage, runs hit/block stun and
// flags KO. All game state advances only on SCEN frame ticks.
//
// Handshake: there is no valid/ready pair here; SCEN is a one-cycle strobe
// that the resolver always accepts, and hit_pulse/block_pulse are one-cycle
// strobes with no back-pressure, asserted on the edge after the SCEN sample.
module hit_resolver
    import fighter_pkg::*;
#(
    parameter int X_W              = DEFAULT_X_W,
    parameter int HEALTH_MAX       = 100,
    parameter int ATK1_DAMAGE      = 8,
    parameter int ATK2_DAMAGE      = 15,
    parameter int CHIP_DAMAGE      = 1,
    parameter int ATK1_REACH       = 40,
    parameter int ATK2_REACH       = 56,
    parameter int BODY_HALF_W      = 16,
    parameter int HITSTUN_FRAMES   = 12,
    parameter int BLOCKSTUN_FRAMES = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           SCEN,
    input  logic           round_reset,
    input  logic           atk_active,
    input  logic [1:0]     atk_type,
    input  logic           atk_busy,
    input  logic [X_W-1:0] atk_x,
    input  logic           atk_facing,
    input  logic [X_W-1:0] def_x,
    input  logic           def_blocking,
    output logic           hit_pulse,
    output logic           block_pulse,
    output logic [6:0]     def_health,
    output logic           def_stun,
    output logic [5:0]     stun_left,
    output logic           ko,
    output logic [1:0]     state_dbg
);

    resolver_state_t state;

    logic [X_W-1:0] reach_sel;
    logic           overlap;
    logic           valid_type;
    logic           connect;
    logic [6:0]     damage;
    logic [5:0]     stun_load;

    hitbox_overlap #(
        .X_W(X_W)
    ) u_overlap (
        .atk_x     (atk_x),
        .atk_facing(atk_facing),
        .reach     (reach_sel),
        .def_x     (def_x),
        .half_w    (X_W'(BODY_HALF_W)),
        .overlap   (overlap)
    );

    // Select reach, damage and stun load for the attack being sampled
    always_comb begin
        reach_sel  = (atk_type == ATK2) ? X_W'(ATK2_REACH) : X_W'(ATK1_REACH);
        valid_type = (atk_type == ATK1) || (atk_type == ATK2);
        connect    = (state == RS_ARMED) && atk_active && valid_type && overlap;
        if (def_blocking) begin
            damage    = 7'(CHIP_DAMAGE);
            stun_load = 6'(BLOCKSTUN_FRAMES);
        end else begin
            damage    = (atk_type == ATK2) ? 7'(ATK2_DAMAGE) : 7'(ATK1_DAMAGE);
            stun_load = 6'(HITSTUN_FRAMES);
        end
    end

    // Resolver FSM with health register, stun counter and one-cycle pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RS_ARMED;
            def_health  <= 7'(HEALTH_MAX);
            stun_left   <= '0;
            hit_pulse   <= 1'b0;
            block_pulse <= 1'b0;
        end else begin
            hit_pulse   <= 1'b0;
            block_pulse <= 1'b0;
            if (round_reset) begin
                state      <= RS_ARMED;
                def_health <= 7'(HEALTH_MAX);
                stun_left  <= '0;
            end else if (SCEN) begin
                case (state)
                    RS_ARMED: begin
                        if (connect) begin
                            hit_pulse   <= ~def_blocking;
                            block_pulse <= def_blocking;
                            if (damage >= def_health) begin
                                def_health <= '0;
                                stun_left  <= '0;
                                state      <= RS_KO;
                            end else begin
                                def_health <= def_health - damage;
                                stun_left  <= stun_load;
                                state      <= RS_CONNECTED;
                            end
                        end else if (stun_left != '0) begin
                            stun_left <= stun_left - 6'd1;
                        end
                    end
                    RS_CONNECTED: begin
                        if (!atk_busy) begin
                            state <= RS_ARMED;
                        end
                        if (stun_left != '0) begin
                            stun_left <= stun_left - 6'd1;
                        end
                    end
                    RS_KO: begin
                        stun_left <= '0;
                    end
                    default: begin
                        state <= RS_ARMED;
                    end
                endcase
            end
        end
    end

    assign def_stun  = (stun_left != '0);
    assign ko        = (state == RS_KO);
    assign state_dbg = state;

endmodule

// File: tb/tb_hit_resolver.sv
// Directed bench for hit_resolver: geometry edges, clean/blocked hits,
// re-arm with combo stun reload, KO saturation and reset priority.
module tb_hit_resolver;

    logic       clk;
    logic       reset;
    logic       SCEN;
    logic       round_reset;
    logic       atk_active;
    logic [1:0] atk_type;
    logic       atk_busy;
    logic [9:0] atk_x;
    logic       atk_facing;
    logic [9:0] def_x;
    logic       def_blocking;
    logic       hit_pulse;
    logic       block_pulse;
    logic [6:0] def_health;
    logic       def_stun;
    logic [5:0] stun_left;
    logic       ko;
    logic [1:0] state_dbg;

    int checks;
    int errors;
    int hit_count;
    logic hit_seen;
    logic block_seen;

    hit_resolver dut (
        .clk         (clk),
        .reset       (reset),
        .SCEN        (SCEN),
        .round_reset (round_reset),
        .atk_active  (atk_active),
        .atk_type    (atk_type),
        .atk_busy    (atk_busy),
        .atk_x       (atk_x),
        .atk_facing  (atk_facing),
        .def_x       (def_x),
        .def_blocking(def_blocking),
        .hit_pulse   (hit_pulse),
        .block_pulse (block_pulse),
        .def_health  (def_health),
        .def_stun    (def_stun),
        .stun_left   (stun_left),
        .ko          (ko),
        .state_dbg   (state_dbg)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame tick: SCEN high for one clock, outputs captured at the next negedge
    task automatic frame(input logic act, input logic busy);
        @(negedge clk);
        atk_active = act;
        atk_busy   = busy;
        SCEN       = 1'b1;
        @(negedge clk);
        SCEN       = 1'b0;
        hit_seen   = hit_pulse;
        block_seen = block_pulse;
        if (hit_pulse) hit_count++;
    endtask

    task automatic do_round_reset();
        @(negedge clk);
        round_reset = 1'b1;
        @(negedge clk);
        round_reset = 1'b0;
    endtask

    // One attack instance that connects on its single active frame, then re-arms
    task automatic do_attack(input logic [1:0] t);
        atk_type = t;
        frame(1'b1, 1'b1);
        frame(1'b0, 1'b0);
    endtask

    initial begin
        checks = 0; errors = 0; hit_count = 0;
        hit_seen = 0; block_seen = 0;
        reset = 1'b1; SCEN = 0; round_reset = 0;
        atk_active = 0; atk_type = 2'd0; atk_busy = 0;
        atk_x = 10'd100; atk_facing = 1'b1; def_x = 10'd130; def_blocking = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_health", def_health, 100);
        check("rst_stun", stun_left, 0);
        check("rst_ko", ko, 0);
        check("rst_pulses", {hit_pulse, block_pulse}, 0);
        check("rst_state", state_dbg, 0);

        // Clean hit, active for frames 4-10 inside busy 3-12
        atk_type = 2'd1;
        for (int f = 1; f <= 16; f++) begin
            frame((f >= 4 && f <= 10), (f >= 3 && f <= 12));
            if (f == 4) begin
                check("t1_hit", {hit_seen, block_seen}, 2'b10);
                check("t1_health", def_health, 92);
                check("t1_stun", stun_left, 12);
                check("t1_state", state_dbg, 1);
                @(negedge clk);
                check("t1_pulse_width", hit_pulse, 0);
            end
            if (f == 10) check("t1_stun_dec", stun_left, 6);
        end
        check("t1_hits", hit_count, 1);
        check("t1_stun_end", stun_left, 0);
        check("t1_def_stun", def_stun, 0);
        check("t1_rearmed", state_dbg, 0);
        frame(1'b0, 1'b0);
        check("t1_stun_sat", stun_left, 0);

        // Miss by one pixel, then edge touch
        do_round_reset();
        atk_type = 2'd2; atk_x = 10'd100; atk_facing = 1'b1; def_x = 10'd173;
        frame(1'b1, 1'b1);
        check("t2_miss_pulse", {hit_seen, block_seen}, 0);
        check("t2_miss_health", def_health, 100);
        def_x = 10'd172;
        frame(1'b1, 1'b1);
        check("t2_edge_hit", {hit_seen, block_seen}, 2'b10);
        check("t2_edge_health", def_health, 85);
        frame(1'b0, 1'b0);

        // Blocked hit while facing left
        do_round_reset();
        atk_type = 2'd2; atk_x = 10'd300; atk_facing = 1'b0; def_x = 10'd270; def_blocking = 1'b1;
        frame(1'b1, 1'b1);
        check("t3_block", {hit_seen, block_seen}, 2'b01);
        check("t3_health", def_health, 99);
        check("t3_stun", stun_left, 6);
        frame(1'b0, 1'b0);
        def_blocking = 1'b0;

        // Re-arm and combo stun reload
        do_round_reset();
        atk_type = 2'd1; atk_x = 10'd100; atk_facing = 1'b1; def_x = 10'd130;
        frame(1'b1, 1'b1);
        check("t4_first", hit_seen, 1);
        frame(1'b0, 1'b1);
        frame(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) frame(1'b0, 1'b1);
        check("t4_stun_before", stun_left, 5);
        frame(1'b1, 1'b1);
        check("t4_second", hit_seen, 1);
        check("t4_health", def_health, 84);
        check("t4_reload", stun_left, 12);
        frame(1'b0, 1'b0);

        // KO saturation
        do_round_reset();
        for (int i = 0; i < 6; i++) do_attack(2'd2);
        check("t5_pre_health", def_health, 10);
        atk_type = 2'd2;
        frame(1'b1, 1'b1);
        check("t5_ko_hit", hit_seen, 1);
        check("t5_ko_health", def_health, 0);
        check("t5_ko_flag", ko, 1);
        check("t5_ko_stun", stun_left, 0);
        check("t5_ko_state", state_dbg, 2);
        frame(1'b0, 1'b0);
        frame(1'b1, 1'b1);
        check("t5_ignored", {hit_seen, block_seen}, 0);
        check("t5_still_zero", def_health, 0);
        frame(1'b0, 1'b0);
        do_round_reset();
        check("t5_rr_health", def_health, 100);
        check("t5_rr_ko", ko, 0);
        check("t5_rr_state", state_dbg, 0);

        // round_reset beats a same-cycle connect
        atk_type = 2'd1;
        frame(1'b1, 1'b1);
        frame(1'b0, 1'b0);
        check("t6_setup_health", def_health, 92);
        @(negedge clk);
        atk_active = 1'b1; atk_busy = 1'b1; SCEN = 1'b1; round_reset = 1'b1;
        @(negedge clk);
        SCEN = 1'b0; round_reset = 1'b0;
        check("t6_no_pulse", {hit_pulse, block_pulse}, 0);
        check("t6_health", def_health, 100);
        check("t6_stun", stun_left, 0);
        atk_active = 1'b0; atk_busy = 1'b0;

        // Async reset mid-stun
        frame(1'b1, 1'b1);
        check("t7_setup_stun", stun_left, 12);
        #2 reset = 1'b1;
        #1;
        check("t7_async_health", def_health, 100);
        check("t7_async_stun", stun_left, 0);
        check("t7_async_state", state_dbg, 0);
        @(negedge clk);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hit_resolver.md
Name: hit_resolver

Overview:
- Consumes the attacker's per-frame attack timing state: active window, attack type and busy flag.
- On each frame tick it checks the attacker hitbox against the defender hurtbox.
- It registers at most one hit per attack instance, applies damage or chip damage, runs defender hit-stun or block-stun, and flags KO.
- It sits between the attack timing stage and the defender's movement/animation and health-bar logic; one instance is used per attacker→defender direction.

Parameters:
X_W, 10, width of horizontal positions (pixels, unsigned)
HEALTH_MAX, 100, starting defender health (must be < 128)
ATK1_DAMAGE, 8, damage for attack type 1
ATK2_DAMAGE, 15, damage for attack type 2
CHIP_DAMAGE, 1, damage applied when the hit is blocked
ATK1_REACH, 40, hitbox length in front of attacker for type 1
ATK2_REACH, 56, hitbox length for type 2
BODY_HALF_W, 16, defender hurtbox half-width
HITSTUN_FRAMES, 12, stun frames loaded on a clean hit
BLOCKSTUN_FRAMES, 6, stun frames loaded on a blocked hit

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
SCEN  in  1  one-cycle frame tick; all game state advances only on this
round_reset  in  1  synchronous; restores health, clears stun/KO/state
atk_active  in  1  attacker hitbox window for the current frame
atk_type  in  2  1 = ATK1, 2 = ATK2; 0 and 3 mean no attack
atk_busy  in  1  attacker is inside an attack
atk_x  in  X_W  attacker x position
atk_facing  in  1  1 = facing right, 0 = facing left
def_x  in  X_W  defender x position (centre)
def_blocking  in  1  defender holding block
hit_pulse  out  1  one clk cycle, a clean hit landed
block_pulse  out  1  one clk cycle, a blocked hit landed
def_health  out  7  current defender health
def_stun  out  1  stun counter non-zero
stun_left  out  6  remaining stun frames
ko  out  1  defender health reached 0

Behaviour:
Reset values (async reset):
- def_health = HEALTH_MAX
- stun_left = 0
- ko = 0
- hit_pulse = 0, block_pulse = 0
- state = ARMED

Hitbox and hurtbox geometry:
- All comparisons use X_W+2-bit signed arithmetic, so nothing wraps near 0 or the screen edge.
- Reach is selected by atk_type.
- Hitbox when facing right: [atk_x, atk_x+reach].
- Hitbox when facing left: [atk_x−reach, atk_x].
- Hurtbox: [def_x−BODY_HALF_W, def_x+BODY_HALF_W].
- overlap = hitbox_lo ≤ hurt_hi AND hurt_lo ≤ hitbox_hi. Edges touching count as overlap.

State machine (advances only on SCEN cycles):
- ARMED:
  - If atk_active, atk_type ∈ {1,2}, and overlap, a connect occurs.
  - Damage = CHIP_DAMAGE if def_blocking, otherwise ATK1_DAMAGE or ATK2_DAMAGE by type.
  - stun_left loads BLOCKSTUN_FRAMES or HITSTUN_FRAMES, overwriting any residual stun (combo reload).
  - State → CONNECTED.
- CONNECTED:
  - Further active frames are ignored.
  - On an SCEN cycle with atk_busy = 0, state → ARMED.
- KO:
  - Entered when the health update yields 0.
  - All connects are ignored; stun_left is forced to 0.
  - Left only via round_reset.

Health arithmetic:
- Saturating subtract: if damage ≥ def_health, def_health = 0 and ko = 1 on the same edge.

Output timing:
- hit_pulse / block_pulse assert for exactly one clk cycle, on the edge following the SCEN cycle in which the connect was sampled.
- def_health and stun_left update on that same edge (latency 1 clk from the SCEN sample).

Stun countdown:
- On an SCEN cycle with no connect, stun_left decrements if non-zero.
- It saturates at 0 and never wraps.
- def_stun = (stun_left ≠ 0).

Non-SCEN cycles:
- No state change.
- Pulses are deasserted.

Simultaneous events:
- round_reset wins over SCEN and any connect. It restores reset values, except that pulses stay at 0.
- A connect on the same SCEN cycle that atk_busy falls still registers; the state goes to CONNECTED and re-arms on the next SCEN cycle with atk_busy = 0.

Mid-operation resets:
- Async reset mid-stun or mid-attack returns immediately to reset values.

Decomposition:
- Shared package fighter_pkg holds:
  - attack type constants ATK_NONE = 0, ATK1 = 1, ATK2 = 2
  - default X_W
  - resolver state encoding (ARMED, CONNECTED, KO)
- One combinational sub-module, hitbox_overlap: inputs atk_x, atk_facing, reach, def_x, half-width; output overlap.
- hit_resolver holds the FSM, health register and stun counter.

Test Plan:
- Overlap, clean hit: atk_x=100, facing=1, def_x=130, type=1, atk_active high for frames 4–10, no block → exactly one hit_pulse; def_health 100→92; stun_left=12, decrementing 1 per SCEN to 0.
- Miss and edge touch: atk_x=100, facing=1, type=2, def_x=173 → no pulse. Same with def_x=172 (hurt_lo=156 = hitbox_hi) → hit, health 100→85.
- Block and facing left: atk_x=300, facing=0, def_x=270, def_blocking=1, type=2 → block_pulse only; health 100→99; stun_left=6.
- Re-arm and combo reload: two back-to-back type-1 attacks, atk_busy dropping for one SCEN between them, second landing when stun_left=5 → two hits; health 84; stun reloads to 12.
- KO saturation: preload health 10 via hits, then a type-2 hit → def_health=0, ko=1; a later hit gives no pulse and no change; round_reset → health=100, ko=0, state ARMED.
- Reset priority: round_reset asserted on the same SCEN cycle as a connect → no pulse; health=100; stun_left=0.
